// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Merges two load/store requesters onto one data-memory port and routes
//   read responses back to the requester that issued them.
//   - Requests go through one output register (EMPTY/HOLD); the register can
//     reload in the same cycle it hands off, so there is no bubble.
//   - Contention is resolved round-robin. Define MEM_ARB_FIXED_PRIORITY_EN
//     to make req0 always win instead.
//   - A tag FIFO of TAG_DEPTH entries records the requester index of each
//     read that reached memory. Responses are steered to the FIFO head.
//   - Null requests (no write or read byte enables) are accepted and dropped.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reqN_* (N=0,1)               requester valid/ready plus request fields
//   mem_*                        registered request toward the memory unit
//   mem_resp_*                   response from the memory unit
//   rspN_* (N=0,1)               response valid/ready plus fields per requester
//   resp_err                     sticky: a response arrived with no read outstanding
//
// State table (request stage)
//   state | meaning
//   EMPTY | no request held, mem_valid=0, the stage may load
//   HOLD  | request held on mem_*, mem_valid=1, waiting for mem_ready
module mem_port_arbiter #(
  parameter int RS_ID_WIDTH = 7,
  parameter int TAG_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [RS_ID_WIDTH-1:0] req0_rs_id,
  input  logic [4:0]             req0_result_reg_addr,
  input  logic [31:0]            req0_address,
  input  logic [3:0]             req0_write_en,
  input  logic [31:0]            req0_write_data,
  input  logic [3:0]             req0_read_en,

  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [RS_ID_WIDTH-1:0] req1_rs_id,
  input  logic [4:0]             req1_result_reg_addr,
  input  logic [31:0]            req1_address,
  input  logic [3:0]             req1_write_en,
  input  logic [31:0]            req1_write_data,
  input  logic [3:0]             req1_read_en,

  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [RS_ID_WIDTH-1:0] mem_rs_id,
  output logic [4:0]             mem_result_reg_addr,
  output logic [31:0]            mem_address,
  output logic [3:0]             mem_write_en,
  output logic [31:0]            mem_write_data,
  output logic [3:0]             mem_read_en,

  input  logic                   mem_resp_valid,
  output logic                   mem_resp_ready,
  input  logic [RS_ID_WIDTH-1:0] mem_resp_rs_id,
  input  logic [4:0]             mem_resp_result_reg_addr,
  input  logic [31:0]            mem_resp_data,

  output logic                   rsp0_valid,
  input  logic                   rsp0_ready,
  output logic [RS_ID_WIDTH-1:0] rsp0_rs_id,
  output logic [4:0]             rsp0_result_reg_addr,
  output logic [31:0]            rsp0_data,

  output logic                   rsp1_valid,
  input  logic                   rsp1_ready,
  output logic [RS_ID_WIDTH-1:0] rsp1_rs_id,
  output logic [4:0]             rsp1_result_reg_addr,
  output logic [31:0]            rsp1_data,

  output logic                   resp_err
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t state_q, state_d;

  logic          wr0, rd0, nul0, wr1, rd1, nul1;
  logic          elig0, elig1, grant0, grant1;
  logic          can_load, load;
  logic          held_rd, held_src;
  logic [CW-1:0] tag_count, tag_occ;
  logic          tag_ok;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          tag_mem [TAG_DEPTH];
  logic          tag_head, fifo_empty, push, pop;

  // Request classes; a write mask takes priority over a read mask.
  assign wr0  = |req0_write_en;
  assign rd0  = ~wr0 & (|req0_read_en);
  assign nul0 = ~wr0 & ~(|req0_read_en);
  assign wr1  = |req1_write_en;
  assign rd1  = ~wr1 & (|req1_read_en);
  assign nul1 = ~wr1 & ~(|req1_read_en);

  // A read sitting in the stage has not been pushed yet but will consume a
  // tag, so it counts as outstanding. Same-cycle pops do not free a slot.
  assign tag_occ = tag_count + CW'(mem_valid & held_rd);
  assign tag_ok  = tag_occ < CW'(TAG_DEPTH);

  assign elig0 = req0_valid & (~rd0 | tag_ok);
  assign elig1 = req1_valid & (~rd1 | tag_ok);

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  assign grant0 = elig0;
  assign grant1 = elig1 & ~elig0;
`else
  logic rr_fav1;  // 1: req1 wins the next contention

  assign grant0 = elig0 & (~elig1 | ~rr_fav1);
  assign grant1 = elig1 & ~grant0;

  always_ff @(posedge clk) begin
    if (rst)       rr_fav1 <= 1'b0;
    else if (load) rr_fav1 <= grant0;
  end
`endif

  assign mem_valid = (state_q == HOLD);
  assign can_load  = (state_q == EMPTY) | mem_ready;
  assign load      = can_load & ((grant0 & ~nul0) | (grant1 & ~nul1));

  assign req0_ready = can_load & grant0;
  assign req1_ready = can_load & grant1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = HOLD;
      HOLD:    if (mem_ready & ~load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rs_id           <= '0;
      mem_result_reg_addr <= '0;
      mem_address         <= '0;
      mem_write_en        <= '0;
      mem_write_data      <= '0;
      mem_read_en         <= '0;
      held_rd             <= 1'b0;
      held_src            <= 1'b0;
    end else if (load) begin
      if (grant1) begin
        mem_rs_id           <= req1_rs_id;
        mem_result_reg_addr <= req1_result_reg_addr;
        mem_address         <= req1_address;
        mem_write_en        <= req1_write_en;
        mem_write_data      <= req1_write_data;
        mem_read_en         <= req1_read_en;
        held_rd             <= rd1;
      end else begin
        mem_rs_id           <= req0_rs_id;
        mem_result_reg_addr <= req0_result_reg_addr;
        mem_address         <= req0_address;
        mem_write_en        <= req0_write_en;
        mem_write_data      <= req0_write_data;
        mem_read_en         <= req0_read_en;
        held_rd             <= rd0;
      end
      held_src <= grant1;
    end
  end

  assign fifo_empty = (tag_count == '0);
  assign tag_head   = tag_mem[rd_ptr];
  assign push       = mem_valid & mem_ready & held_rd;
  assign pop        = mem_resp_valid & mem_resp_ready & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= held_src;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   tag_count <= tag_count + CW'(1);
        2'b01:   tag_count <= tag_count - CW'(1);
        default: tag_count <= tag_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                              resp_err <= 1'b0;
    else if (mem_resp_valid & fifo_empty) resp_err <= 1'b1;
  end

  // With no read outstanding the response is swallowed (ready=1).
  always_comb begin
    rsp0_valid     = 1'b0;
    rsp1_valid     = 1'b0;
    mem_resp_ready = 1'b1;
    if (!fifo_empty) begin
      if (tag_head) begin
        rsp1_valid     = mem_resp_valid;
        mem_resp_ready = rsp1_ready;
      end else begin
        rsp0_valid     = mem_resp_valid;
        mem_resp_ready = rsp0_ready;
      end
    end
  end

  assign rsp0_rs_id           = mem_resp_rs_id;
  assign rsp0_result_reg_addr = mem_resp_result_reg_addr;
  assign rsp0_data            = mem_resp_data;
  assign rsp1_rs_id           = mem_resp_rs_id;
  assign rsp1_result_reg_addr = mem_resp_result_reg_addr;
  assign rsp1_data            = mem_resp_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int DEPTH = 4;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [6:0]  req0_rs_id, req1_rs_id;
  logic [4:0]  req0_result_reg_addr, req1_result_reg_addr;
  logic [31:0] req0_address, req1_address, req0_write_data, req1_write_data;
  logic [3:0]  req0_write_en, req1_write_en, req0_read_en, req1_read_en;
  logic        mem_valid, mem_ready;
  logic [6:0]  mem_rs_id;
  logic [4:0]  mem_result_reg_addr;
  logic [31:0] mem_address, mem_write_data;
  logic [3:0]  mem_write_en, mem_read_en;
  logic        mem_resp_valid, mem_resp_ready;
  logic [6:0]  mem_resp_rs_id;
  logic [4:0]  mem_resp_result_reg_addr;
  logic [31:0] mem_resp_data;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [6:0]  rsp0_rs_id, rsp1_rs_id;
  logic [4:0]  rsp0_result_reg_addr, rsp1_result_reg_addr;
  logic [31:0] rsp0_data, rsp1_data;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RS_ID_WIDTH(7), .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs_id(req0_rs_id),
    .req0_result_reg_addr(req0_result_reg_addr), .req0_address(req0_address),
    .req0_write_en(req0_write_en), .req0_write_data(req0_write_data), .req0_read_en(req0_read_en),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs_id(req1_rs_id),
    .req1_result_reg_addr(req1_result_reg_addr), .req1_address(req1_address),
    .req1_write_en(req1_write_en), .req1_write_data(req1_write_data), .req1_read_en(req1_read_en),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rs_id(mem_rs_id),
    .mem_result_reg_addr(mem_result_reg_addr), .mem_address(mem_address),
    .mem_write_en(mem_write_en), .mem_write_data(mem_write_data), .mem_read_en(mem_read_en),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rs_id(mem_resp_rs_id),
    .mem_resp_result_reg_addr(mem_resp_result_reg_addr), .mem_resp_data(mem_resp_data),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rs_id(rsp0_rs_id),
    .rsp0_result_reg_addr(rsp0_result_reg_addr), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rs_id(rsp1_rs_id),
    .rsp1_result_reg_addr(rsp1_result_reg_addr), .rsp1_data(rsp1_data),
    .resp_err(resp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_req(input int n, input logic v, input logic [3:0] we, input logic [3:0] re,
                           input logic [31:0] addr, input logic [6:0] rs);
    if (n == 0) begin
      req0_valid = v; req0_write_en = we; req0_read_en = re; req0_address = addr;
      req0_rs_id = rs; req0_write_data = addr ^ 32'h5a5a0000; req0_result_reg_addr = addr[6:2];
    end else begin
      req1_valid = v; req1_write_en = we; req1_read_en = re; req1_address = addr;
      req1_rs_id = rs; req1_write_data = addr ^ 32'h5a5a0000; req1_result_reg_addr = addr[6:2];
    end
  endtask

  task automatic idle();
    drive_req(0, 1'b0, 4'h0, 4'h0, 32'h0, 7'h0);
    drive_req(1, 1'b0, 4'h0, 4'h0, 32'h0, 7'h0);
    mem_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_rs_id = 7'h0; mem_resp_result_reg_addr = 5'h0; mem_resp_data = 32'h0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        v0;
    logic [3:0]  we0, re0;
    logic [31:0] a0;
    logic        v1;
    logic [3:0]  we1, re1;
    logic [31:0] a1;
    logic        e_r0, e_r1, e_mv;
    logic [31:0] e_addr;
    logic [3:0]  e_we;
  } vec_t;

  vec_t vt[7];

  // Behavioural reference state for the random phase.
  int          q[$];
  bit          h_v, h_rd, h_src, fav, m_err;
  logic [31:0] h_addr;
  logic [6:0]  h_rs;

  function automatic int cls_of(input logic [3:0] we, input logic [3:0] re);
    if (we != 4'h0) return 2;
    if (re != 4'h0) return 1;
    return 0;
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    do_reset();

    // Reset state
    settle();
    chk("rst mem_valid", mem_valid, 0);
    chk("rst resp_err", resp_err, 0);
    chk("rst rsp0_valid", rsp0_valid, 0);
    chk("rst rsp1_valid", rsp1_valid, 0);
    chk("rst mem_address", mem_address, 0);
    chk("rst mem_resp_ready", mem_resp_ready, 1);

    // Single-cycle vectors from a fresh reset (req0 favoured).
    vt[0] = '{1'b0, 4'h0, 4'h0, 32'h00, 1'b0, 4'h0, 4'h0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 4'h0};
    vt[1] = '{1'b1, 4'hf, 4'h0, 32'h10, 1'b0, 4'h0, 4'h0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h10, 4'hf};
    vt[2] = '{1'b0, 4'h0, 4'h0, 32'h00, 1'b1, 4'h0, 4'hf, 32'h20, 1'b0, 1'b1, 1'b1, 32'h20, 4'h0};
    vt[3] = '{1'b1, 4'h3, 4'h0, 32'h30, 1'b1, 4'hc, 4'h0, 32'h40, 1'b1, 1'b0, 1'b1, 32'h30, 4'h3};
    vt[4] = '{1'b1, 4'h0, 4'h0, 32'h44, 1'b0, 4'h0, 4'h0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 4'h0};
    vt[5] = '{1'b1, 4'h1, 4'hf, 32'h60, 1'b0, 4'h0, 4'h0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h60, 4'h1};
    vt[6] = '{1'b1, 4'h0, 4'hf, 32'h70, 1'b1, 4'hf, 4'h0, 32'h74, 1'b1, 1'b0, 1'b1, 32'h70, 4'h0};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      drive_req(0, vt[i].v0, vt[i].we0, vt[i].re0, vt[i].a0, 7'(i));
      drive_req(1, vt[i].v1, vt[i].we1, vt[i].re1, vt[i].a1, 7'(i + 8));
      settle();
      chk($sformatf("vec%0d ready0", i), req0_ready, vt[i].e_r0);
      chk($sformatf("vec%0d ready1", i), req1_ready, vt[i].e_r1);
      tick();
      chk($sformatf("vec%0d mem_valid", i), mem_valid, vt[i].e_mv);
      if (vt[i].e_mv) begin
        chk($sformatf("vec%0d mem_address", i), mem_address, vt[i].e_addr);
        chk($sformatf("vec%0d mem_write_en", i), mem_write_en, vt[i].e_we);
      end
    end

    // Continuous reads from both requesters
    do_reset();
    drive_req(0, 1'b1, 4'h0, 4'hf, 32'h1000, 7'h1);
    drive_req(1, 1'b1, 4'h0, 4'hf, 32'h2000, 7'h2);
    for (int k = 0; k < 4; k++) begin
      logic e0;
      e0 = FIXED ? 1'b1 : ((k % 2) == 0);
      settle();
      chk($sformatf("rr grant%0d ready0", k), req0_ready, e0);
      chk($sformatf("rr grant%0d ready1", k), req1_ready, !e0);
      tick();
    end

    // Stalled write held stable
    do_reset();
    mem_ready = 1'b0;
    drive_req(1, 1'b1, 4'hf, 4'h0, 32'h100, 7'h5);
    settle();
    chk("stall accept ready1", req1_ready, 1);
    tick();
    drive_req(0, 1'b1, 4'hf, 4'h0, 32'h200, 7'h6);
    drive_req(1, 1'b1, 4'hf, 4'h0, 32'h300, 7'h7);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("stall mem_valid", mem_valid, 1);
      chk("stall mem_address", mem_address, 32'h100);
      chk("stall mem_write_data", mem_write_data, 32'h5a5a0100);
      chk("stall mem_rs_id", mem_rs_id, 7'h5);
      chk("stall ready0", req0_ready, 0);
      chk("stall ready1", req1_ready, 0);
      tick();
    end
    mem_ready = 1'b1;
    settle();
    chk("stall release mem_address", mem_address, 32'h100);
    chk("stall release ready0", req0_ready, 1);
    chk("stall release ready1", req1_ready, 0);
    tick();
    chk("stall next mem_address", mem_address, 32'h200);

    // Tag FIFO full
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_req(0, 1'b1, 4'h0, 4'hf, 32'h400 + 32'(k * 4), 7'(k));
      settle();
      chk($sformatf("full read%0d ready0", k), req0_ready, 1);
      tick();
    end
    drive_req(0, 1'b1, 4'h0, 4'hf, 32'h500, 7'h9);
    drive_req(1, 1'b1, 4'hf, 4'h0, 32'h600, 7'h3);
    settle();
    chk("full fifth read ready0", req0_ready, 0);
    chk("full write ready1", req1_ready, 1);
    tick();
    drive_req(1, 1'b0, 4'h0, 4'h0, 32'h0, 7'h0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'haaa1;
    settle();
    chk("full pop rsp0_valid", rsp0_valid, 1);
    chk("full pop rsp0_data", rsp0_data, 32'haaa1);
    chk("full pop mem_resp_ready", mem_resp_ready, 1);
    chk("full pop ready0", req0_ready, 0);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    chk("full freed ready0", req0_ready, 1);
    tick();

    // Response routing by tag order
    do_reset();
    drive_req(0, 1'b1, 4'h0, 4'hf, 32'h700, 7'h1);
    tick();
    drive_req(0, 1'b0, 4'h0, 4'h0, 32'h0, 7'h0);
    drive_req(1, 1'b1, 4'h0, 4'hf, 32'h704, 7'h2);
    tick();
    drive_req(1, 1'b0, 4'h0, 4'h0, 32'h0, 7'h0);
    drive_req(0, 1'b1, 4'h0, 4'hf, 32'h708, 7'h3);
    tick();
    drive_req(0, 1'b0, 4'h0, 4'h0, 32'h0, 7'h0);
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'ha; mem_resp_rs_id = 7'h1;
    settle();
    chk("route A rsp0_valid", rsp0_valid, 1);
    chk("route A rsp1_valid", rsp1_valid, 0);
    chk("route A rsp0_data", rsp0_data, 32'ha);
    chk("route A rsp0_rs_id", rsp0_rs_id, 7'h1);
    tick();
    mem_resp_data = 32'hb; rsp1_ready = 1'b0;
    settle();
    chk("route B rsp1_valid", rsp1_valid, 1);
    chk("route B rsp0_valid", rsp0_valid, 0);
    chk("route B stall mem_resp_ready", mem_resp_ready, 0);
    tick();
    rsp1_ready = 1'b1;
    settle();
    chk("route B mem_resp_ready", mem_resp_ready, 1);
    chk("route B rsp1_data", rsp1_data, 32'hb);
    tick();
    mem_resp_data = 32'hc;
    settle();
    chk("route C rsp0_valid", rsp0_valid, 1);
    chk("route C rsp1_valid", rsp1_valid, 0);
    chk("route C rsp0_data", rsp0_data, 32'hc);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    chk("route resp_err clear", resp_err, 0);
    tick();

    // Unexpected response
    mem_resp_valid = 1'b1; mem_resp_data = 32'hd;
    settle();
    chk("unexp mem_resp_ready", mem_resp_ready, 1);
    chk("unexp rsp0_valid", rsp0_valid, 0);
    chk("unexp rsp1_valid", rsp1_valid, 0);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    chk("unexp resp_err set", resp_err, 1);
    tick();
    tick();
    chk("unexp resp_err sticky", resp_err, 1);
    do_reset();
    settle();
    chk("unexp resp_err after rst", resp_err, 0);

    // Reset with a held read and two tags outstanding
    do_reset();
    drive_req(0, 1'b1, 4'h0, 4'hf, 32'h800, 7'h1);
    tick();
    drive_req(0, 1'b0, 4'h0, 4'h0, 32'h0, 7'h0);
    drive_req(1, 1'b1, 4'h0, 4'hf, 32'h804, 7'h2);
    tick();
    drive_req(1, 1'b0, 4'h0, 4'h0, 32'h0, 7'h0);
    drive_req(0, 1'b1, 4'h0, 4'hf, 32'h808, 7'h3);
    tick();
    drive_req(0, 1'b0, 4'h0, 4'h0, 32'h0, 7'h0);
    mem_ready = 1'b0;
    settle();
    chk("midrst pre mem_valid", mem_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    settle();
    chk("midrst mem_valid", mem_valid, 0);
    chk("midrst resp_err", resp_err, 0);
    mem_resp_valid = 1'b1;
    #1;
    chk("midrst rsp0_valid", rsp0_valid, 0);
    chk("midrst rsp1_valid", rsp1_valid, 0);
    chk("midrst mem_resp_ready", mem_resp_ready, 1);
    tick();

    // Randomized traffic against the reference model
    do_reset();
    q.delete();
    h_v = 0; h_rd = 0; h_src = 0; fav = 0; m_err = 0; h_addr = '0; h_rs = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int c0, c1, outst, win;
      bit ok0, ok1, stall, e_r0, e_r1, e_v0, e_v1, e_mrr;
      for (int n = 0; n < 2; n++) begin
        int kind;
        logic [3:0] we, re;
        kind = $urandom_range(0, 3);
        we = (kind >= 2) ? 4'($urandom_range(1, 15)) : 4'h0;
        re = (kind == 1 || kind == 3) ? 4'($urandom_range(1, 15)) : 4'h0;
        drive_req(n, $urandom_range(0, 3) != 0, we, re, $urandom, 7'($urandom));
      end
      mem_ready      = $urandom_range(0, 3) != 0;
      mem_resp_valid = $urandom_range(0, 2) == 0;
      mem_resp_data  = $urandom;
      mem_resp_rs_id = 7'($urandom);
      rsp0_ready     = $urandom_range(0, 3) != 0;
      rsp1_ready     = $urandom_range(0, 3) != 0;
      settle();

      c0 = cls_of(req0_write_en, req0_read_en);
      c1 = cls_of(req1_write_en, req1_read_en);
      outst = q.size() + ((h_v && h_rd) ? 1 : 0);
      ok0 = req0_valid && (c0 != 1 || outst < DEPTH);
      ok1 = req1_valid && (c1 != 1 || outst < DEPTH);
      stall = h_v && !mem_ready;
      win = -1;
      if (ok0 && ok1) win = FIXED ? 0 : (fav ? 1 : 0);
      else if (ok0)   win = 0;
      else if (ok1)   win = 1;
      e_r0 = !stall && win == 0;
      e_r1 = !stall && win == 1;
      if (q.size() == 0) begin
        e_mrr = 1; e_v0 = 0; e_v1 = 0;
      end else if (q[0] == 0) begin
        e_mrr = rsp0_ready; e_v0 = mem_resp_valid; e_v1 = 0;
      end else begin
        e_mrr = rsp1_ready; e_v0 = 0; e_v1 = mem_resp_valid;
      end

      chk("rnd ready0", req0_ready, e_r0);
      chk("rnd ready1", req1_ready, e_r1);
      chk("rnd mem_valid", mem_valid, h_v);
      if (h_v) begin
        chk("rnd mem_address", mem_address, h_addr);
        chk("rnd mem_rs_id", mem_rs_id, h_rs);
      end
      chk("rnd mem_resp_ready", mem_resp_ready, e_mrr);
      chk("rnd rsp0_valid", rsp0_valid, e_v0);
      chk("rnd rsp1_valid", rsp1_valid, e_v1);
      chk("rnd resp_err", resp_err, m_err);
      chk("rnd rsp1_rs_id", rsp1_rs_id, mem_resp_rs_id);

      if (mem_resp_valid && q.size() != 0 && e_mrr) void'(q.pop_front());
      else if (mem_resp_valid && q.size() == 0)    m_err = 1;
      if (h_v && mem_ready && h_rd) q.push_back(int'(h_src));
      if (win >= 0 && !stall && ((win == 0) ? c0 : c1) != 0) begin
        h_v    = 1;
        h_src  = (win == 1);
        h_rd   = ((win == 0) ? c0 : c1) == 1;
        h_addr = (win == 0) ? req0_address : req1_address;
        h_rs   = (win == 0) ? req0_rs_id : req1_rs_id;
        fav    = (win == 0);
      end else if (mem_ready) begin
        h_v = 0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
